// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, register IDs and writeback FSM state encoding.
package y86_pkg;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

    localparam logic [3:0]  RRSP     = 4'd4;
    localparam logic [3:0]  RNONE    = 4'hF;
    localparam int unsigned NUM_REGS = 15;

endpackage

// File: rtl/y86_regfile.sv
// Y86 register storage: 15 x 64-bit, two combinational read ports, two write ports (M wins on collision).
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rdata_a,
    output logic [63:0] rdata_b
);

    logic [63:0] regs_q [NUM_REGS];
    logic [63:0] regs_d [NUM_REGS];

    // M port is applied after E so it overrides when both target the same register.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (we_e && dst_e == 4'(i)) regs_d[i] = val_e;
            if (we_m && dst_m == 4'(i)) regs_d[i] = val_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (src_a != RNONE) rdata_a = regs_q[src_a];
        if (src_b != RNONE) rdata_b = regs_q[src_b];
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86 writeback stage: RUN/HALTED FSM, status latch, retired-instruction counter and register file.
// Define WB_BYPASS_EN to forward same-cycle writeback data onto valA/valB.
module writeback_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  stat_in,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [1:0]  stat_out,
    output logic        halted,
    output logic [63:0] instr_count
);

    wb_state_e   state_q, state_d;
    stat_e       stat_q, stat_d;
    logic [63:0] count_q, count_d;
    logic        wr_en;
    logic        we_e, we_m;
    logic [63:0] rd_a, rd_b;

    assign wr_en = (state_q == ST_RUN) && (stat_in == STAT_AOK);
    assign we_e  = wr_en && (dstE != RNONE);
    assign we_m  = wr_en && (dstM != RNONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            stat_q  <= STAT_AOK;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        if (state_q == ST_RUN && stat_in != STAT_AOK) begin
            state_d = ST_HALTED;
            stat_d  = stat_e'(stat_in);
        end
        count_d = wr_en ? count_q + 64'd1 : count_q;
    end

    always_comb begin
        halted      = (state_q == ST_HALTED);
        stat_out    = stat_q;
        instr_count = count_q;
    end

    y86_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_e    (we_e),
        .dst_e   (dstE),
        .val_e   (valE),
        .we_m    (we_m),
        .dst_m   (dstM),
        .val_m   (valM),
        .src_a   (srcA),
        .src_b   (srcB),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

`ifdef WB_BYPASS_EN
    // Forwarding mirrors the write-port priority: M beats E beats stored data.
    always_comb begin
        valA = rd_a;
        valB = rd_b;
        if (srcA != RNONE) begin
            if (we_m && srcA == dstM)      valA = valM;
            else if (we_e && srcA == dstE) valA = valE;
        end
        if (srcB != RNONE) begin
            if (we_m && srcB == dstM)      valB = valM;
            else if (we_e && srcB == dstE) valB = valE;
        end
    end
`else
    always_comb begin
        valA = rd_a;
        valB = rd_b;
    end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Testbench for writeback_regfile: directed vector table, same-cycle read sequence, randomized model check.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  stat_in;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic [63:0] valE, valM;
    logic [63:0] valA, valB;
    logic [1:0]  stat_out;
    logic        halted;
    logic [63:0] instr_count;

    int checks = 0;
    int errors = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    writeback_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .stat_in     (stat_in),
        .dstE        (dstE),
        .dstM        (dstM),
        .valE        (valE),
        .valM        (valM),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .stat_out    (stat_out),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  stat;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [63:0] expa;
        logic [63:0] expb;
        logic        exph;
        logic [1:0]  exps;
        logic [63:0] expc;
    } vec_t;

    vec_t vecs [11];

    // Behavioural reference state for the random phase.
    logic [63:0] m_regs [15];
    logic        m_halted;
    logic [1:0]  m_stat;
    logic [63:0] m_cnt;

    function automatic logic [63:0] m_read(input logic [3:0] src, input logic [1:0] st,
                                           input logic [3:0] de, input logic [63:0] ve,
                                           input logic [3:0] dm, input logic [63:0] vm);
        logic live;
        if (src == 4'hF) return 64'd0;
        live = BYP && !m_halted && st == 2'b00;
        if (live && src == dm) return vm;
        if (live && src == de) return ve;
        return m_regs[src];
    endfunction

    task automatic m_step(input logic rst, input logic [1:0] st,
                          input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 64'd0;
            m_halted = 1'b0;
            m_stat   = 2'b00;
            m_cnt    = 64'd0;
        end else if (!m_halted) begin
            if (st != 2'b00) begin
                m_halted = 1'b1;
                m_stat   = st;
            end else begin
                if (de != 4'hF) m_regs[de] = ve;
                if (dm != 4'hF) m_regs[dm] = vm;
                m_cnt = m_cnt + 64'd1;
            end
        end
    endtask

    task automatic idle_inputs();
        stat_in = 2'b00;
        dstE = 4'hF; dstM = 4'hF;
        valE = '0;   valM = '0;
        srcA = 4'hF; srcB = 4'hF;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 4'hF, 4'hF, 64'd0,   64'd0,  4'd3, 4'd4, 64'd0,   64'd0,  1'b0, 2'b00, 64'd0};
        vecs[1]  = '{1'b0, 2'b00, 4'd3, 4'hF, 64'd100, 64'd5,  4'd3, 4'hF, 64'd100, 64'd0,  1'b0, 2'b00, 64'd1};
        vecs[2]  = '{1'b0, 2'b00, 4'd4, 4'd4, 64'd200, 64'd49, 4'd4, 4'd3, 64'd49,  64'd100, 1'b0, 2'b00, 64'd2};
        vecs[3]  = '{1'b0, 2'b00, 4'hF, 4'hF, 64'd7,   64'd8,  4'd3, 4'd4, 64'd100, 64'd49, 1'b0, 2'b00, 64'd3};
        vecs[4]  = '{1'b0, 2'b00, 4'd7, 4'd14, 64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000,
                     4'd7, 4'd14, 64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000, 1'b0, 2'b00, 64'd4};
        vecs[5]  = '{1'b0, 2'b10, 4'd1, 4'hF, 64'd77,  64'd0,  4'd1, 4'd3, 64'd0,   64'd100, 1'b1, 2'b10, 64'd4};
        vecs[6]  = '{1'b0, 2'b00, 4'd2, 4'hF, 64'd55,  64'd0,  4'd2, 4'd1, 64'd0,   64'd0,  1'b1, 2'b10, 64'd4};
        vecs[7]  = '{1'b0, 2'b11, 4'd3, 4'd0, 64'd1,   64'd2,  4'd3, 4'd0, 64'd100, 64'd0,  1'b1, 2'b10, 64'd4};
        vecs[8]  = '{1'b1, 2'b00, 4'd5, 4'hF, 64'd9,   64'd0,  4'd5, 4'd3, 64'd0,   64'd0,  1'b0, 2'b00, 64'd0};
        vecs[9]  = '{1'b0, 2'b01, 4'd9, 4'hF, 64'd4,   64'd0,  4'd9, 4'hF, 64'd0,   64'd0,  1'b1, 2'b01, 64'd0};
        vecs[10] = '{1'b1, 2'b00, 4'd5, 4'd5, 64'd9,   64'd3,  4'd5, 4'd9, 64'd0,   64'd0,  1'b0, 2'b00, 64'd0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            reset   = vecs[v].rst;
            stat_in = vecs[v].stat;
            dstE    = vecs[v].dste;  dstM = vecs[v].dstm;
            valE    = vecs[v].vale;  valM = vecs[v].valm;
            srcA    = 4'hF;          srcB = 4'hF;
            @(posedge clk);
            #1;
            reset = 1'b0;
            idle_inputs();
            srcA = vecs[v].srca;
            srcB = vecs[v].srcb;
            #1;
            chk($sformatf("vec%0d_valA", v), valA, vecs[v].expa);
            chk($sformatf("vec%0d_valB", v), valB, vecs[v].expb);
            chk($sformatf("vec%0d_halted", v), 64'(halted), 64'(vecs[v].exph));
            chk($sformatf("vec%0d_stat_out", v), 64'(stat_out), 64'(vecs[v].exps));
            chk($sformatf("vec%0d_count", v), instr_count, vecs[v].expc);
        end

        // Same-cycle read of a register being written (state is fresh from reset).
        srcA = 4'd6; dstE = 4'd6; valE = 64'hFFFF_FFFF_FFFF_FFCF; stat_in = 2'b00;
        #1;
        chk("same_cycle_valA", valA, BYP ? 64'hFFFF_FFFF_FFFF_FFCF : 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        srcA = 4'd6;
        #1;
        chk("after_edge_valA", valA, 64'hFFFF_FFFF_FFFF_FFCF);
        chk("after_edge_count", instr_count, 64'd1);

        srcB = 4'd6; dstE = 4'd6; valE = 64'd1; dstM = 4'd6; valM = 64'd2;
        #1;
        chk("bypass_m_prio_valB", valB, BYP ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFCF);
        stat_in = 2'b01;
        #1;
        chk("no_bypass_on_halt_edge", valB, 64'hFFFF_FFFF_FFFF_FFCF);
        stat_in = 2'b00; srcA = 4'hF;
        #1;
        chk("rnone_read_zero", valA, 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        srcA = 4'd6;
        #1;
        chk("m_prio_stored", valA, 64'd2);
        chk("m_prio_count", instr_count, 64'd2);

        // Randomized phase against the behavioural model.
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_step(1'b1, 2'b00, 4'hF, 64'd0, 4'hF, 64'd0);
        for (int n = 0; n < 400; n++) begin
            logic [63:0] ea, eb;
            reset   = (m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 59) == 0);
            stat_in = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            dstE    = 4'($urandom_range(0, 15));
            dstM    = ($urandom_range(0, 3) == 0) ? dstE : 4'($urandom_range(0, 15));
            valE    = {$urandom, $urandom};
            valM    = {$urandom, $urandom};
            srcA    = ($urandom_range(0, 2) == 0) ? dstE : 4'($urandom_range(0, 15));
            srcB    = ($urandom_range(0, 2) == 0) ? dstM : 4'($urandom_range(0, 15));
            #1;
            ea = m_read(srcA, stat_in, dstE, valE, dstM, valM);
            eb = m_read(srcB, stat_in, dstE, valE, dstM, valM);
            chk("rand_valA", valA, ea);
            chk("rand_valB", valB, eb);
            @(posedge clk);
            m_step(reset, stat_in, dstE, valE, dstM, valM);
            #1;
            chk("rand_halted", 64'(halted), 64'(m_halted));
            chk("rand_stat_out", 64'(stat_out), 64'(m_stat));
            chk("rand_count", instr_count, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have ports: stat_in  input  2  status of the instruction in writeback; 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-004 SHALL have ports: dstE  input  4  register ID for valE write; 4'hF = RNONE (no write).
REQ-005 SHALL have ports: dstM  input  4  register ID for valM write; 4'hF = RNONE.
REQ-006 SHALL have ports: valE  input  64  execute result (signed).
REQ-007 SHALL have ports: valM  input  64  memory-stage read data (signed).
REQ-008 SHALL have ports: srcA, srcB  input  4 each  decode read selects; 4'hF = RNONE.
REQ-009 SHALL have ports: valA, valB  output  64 each  read data for srcA/srcB.
REQ-010 SHALL have ports: stat_out  output  2  processor status; halted  output  1  high in HALTED; instr_count  output  64  retired-instruction count.

Function
REQ-011 SHALL hold 15 x 64-bit registers, IDs 0..14 (%rax..%r14).
REQ-012 SHALL read combinationally; valA/valB SHALL be 0 when the selector is RNONE.
REQ-013 SHALL, in RUN with stat_in = AOK, write valE to dstE and valM to dstM on the rising edge; RNONE targets write nothing.
REQ-014 SHALL, when dstE = dstM != RNONE, write valM only (M port priority).
REQ-015 SHALL have a two-state FSM: RUN -> HALTED when stat_in != AOK at a rising edge in RUN; HALTED -> RUN only via reset.
REQ-016 SHALL suppress all register writes in the edge that moves RUN -> HALTED and in every HALTED cycle.
REQ-017 SHALL latch stat_in into stat_out on the RUN -> HALTED edge and hold it; stat_out = AOK in RUN.
REQ-018 SHALL increment instr_count by 1 on each edge in RUN with stat_in = AOK; 64-bit wrap 2^64-1 -> 0; frozen in HALTED.
REQ-019 SHALL return the pre-edge register value on reads in the same cycle as a write unless WB_BYPASS_EN is defined (REQ-023).

Reset
REQ-020 SHALL on reset: all 15 registers = 0, FSM = RUN, stat_out = 00, halted = 0, instr_count = 0.
REQ-021 SHALL give reset priority over any simultaneous write, halt transition or count increment, including a reset while HALTED.

Configuration
REQ-022 SHALL compile the bypass path only when macro WB_BYPASS_EN is defined.
REQ-023 SHALL with WB_BYPASS_EN: valA/valB return valM (if src = dstM and the write is enabled), else valE (if src = dstE and the write is enabled), else the stored value; without it: stored value only.

Structure
REQ-024 SHALL take stat codes (STAT_AOK/HLT/ADR/INS), register IDs (RRSP = 4, RNONE = 4'hF) and FSM state encoding from shared package y86_pkg.
REQ-025 SHALL instantiate one sub-module y86_regfile (storage, 2 read / 2 write ports); the FSM, counter and bypass SHALL stay in writeback_regfile.

Verification
REQ-026 SHALL cover: reset, then dstE=3 valE=100, dstM=F, stat AOK, one edge -> srcA=3 gives valA=100, instr_count=1.
REQ-027 SHALL cover: dstE=4 valE=200, dstM=4 valM=49, same edge -> reg 4 = 49 (M priority).
REQ-028 SHALL cover: stat_in=10 (ADR) with dstE=1 valE=77 -> reg 1 unchanged, halted=1, stat_out=10; a following AOK write of dstE=2 is ignored; instr_count frozen.
REQ-029 SHALL cover: reset asserted while HALTED with dstE=5 valE=9 -> reg 5 = 0, halted=0, stat_out=00, instr_count=0.
REQ-030 SHALL cover: srcA=6, dstE=6 valE=-49 in the same cycle -> valA=-49 with WB_BYPASS_EN, old value (0 after reset) without.
REQ-031 SHALL cover: srcB=F -> valB=0; dstE=F, dstM=F, stat AOK -> no register changes, instr_count increments.
